// File: rtl/word_packer_pkg.sv
// rtl/word_packer_pkg.sv - shared widths and types for the 32-to-128 word packer
package word_packer_pkg;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   typedef logic [LANES-1:0][WORD_W-1:0] beat_t;
   typedef logic [$clog2(LANES)-1:0]     lane_idx_t;
endpackage

// File: rtl/word_packer_lane_mux.sv
// rtl/word_packer_lane_mux.sv - builds a zero-padded beat from collected lanes plus the closing word
module word_packer_lane_mux #(
   parameter  int WORD_W = 32,
   parameter  int LANES  = 4,
   localparam int IDX_W  = $clog2(LANES)
) (
   input  logic [LANES-2:0][WORD_W-1:0] acc_i,
   input  logic [IDX_W-1:0]             cnt_i,
   input  logic [WORD_W-1:0]            word_i,
   output logic [LANES-1:0][WORD_W-1:0] beat_o
);

   // Lanes above the closing lane stay zero even if acc were ever non-zero there.
   always_comb begin
      beat_o = '0;
      for (int l = 0; l < LANES - 1; l++) begin
         if (l < int'(cnt_i)) beat_o[l] = acc_i[l];
      end
      beat_o[cnt_i] = word_i;
   end

endmodule

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs LANES input words into one wide beat for the downstream FIFO enq
module word_packer #(
   parameter int WORD_W = word_packer_pkg::WORD_W,
   parameter int LANES  = word_packer_pkg::LANES,
   parameter int CNT_W  = 16
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      in_enq_ena,
   input  logic [WORD_W-1:0]         in_enq_v,
   input  logic                      in_enq_last,
   output logic                      in_enq_rdy,
   output logic                      out_enq_ena,
   output logic [WORD_W*LANES-1:0]   out_enq_v,
   input  logic                      out_enq_rdy,
   output logic [CNT_W-1:0]          beats_out
);
   import word_packer_pkg::*;

   localparam int IDX_W = $clog2(LANES);

   logic [IDX_W-1:0]             cnt_q, cnt_d;
   logic [LANES-2:0][WORD_W-1:0] acc_q, acc_d;
   logic [LANES-1:0][WORD_W-1:0] hold_v_q, hold_v_d;
   logic                         hold_valid_q, hold_valid_d;
   logic [CNT_W-1:0]             beats_q, beats_d;

   logic [LANES-1:0][WORD_W-1:0] beat_new;
   logic                         in_xfer, out_xfer, beat_close;

   assign in_enq_rdy  = !hold_valid_q | out_enq_rdy;
   assign out_enq_ena = hold_valid_q;
   assign out_enq_v   = hold_v_q;
   assign beats_out   = beats_q;

   assign in_xfer    = in_enq_ena & in_enq_rdy;
   assign out_xfer   = hold_valid_q & out_enq_rdy;
   assign beat_close = in_xfer & ((cnt_q == IDX_W'(LANES - 1)) | in_enq_last);

   word_packer_lane_mux #(
      .WORD_W (WORD_W),
      .LANES  (LANES)
   ) u_lane_mux (
      .acc_i  (acc_q),
      .cnt_i  (cnt_q),
      .word_i (in_enq_v),
      .beat_o (beat_new)
   );

   // A beat close in the same cycle as an output transfer overrides the clear of hold_valid.
   always_comb begin
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      hold_v_d     = hold_v_q;
      hold_valid_d = hold_valid_q;
      beats_d      = beats_q;
      if (out_xfer) begin
         hold_valid_d = 1'b0;
         beats_d      = beats_q + 1'b1;
      end
      if (beat_close) begin
         hold_v_d     = beat_new;
         hold_valid_d = 1'b1;
         cnt_d        = '0;
         acc_d        = '0;
      end else if (in_xfer) begin
         acc_d[cnt_q] = in_enq_v;
         cnt_d        = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt_q        <= '0;
         acc_q        <= '0;
         hold_v_q     <= '0;
         hold_valid_q <= 1'b0;
         beats_q      <= '0;
      end else begin
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         hold_v_q     <= hold_v_d;
         hold_valid_q <= hold_valid_d;
         beats_q      <= beats_d;
      end
   end

endmodule

// File: tb/tb_word_packer.sv
// tb/tb_word_packer.sv - directed and randomized checks of word_packer against a queue-based model
module tb_word_packer;
   import word_packer_pkg::*;

   logic                     CLK;
   logic                     nRST;
   logic                     in_enq_ena;
   logic [WORD_W-1:0]        in_enq_v;
   logic                     in_enq_last;
   logic                     in_enq_rdy;
   logic                     out_enq_ena;
   logic [WORD_W*LANES-1:0]  out_enq_v;
   logic                     out_enq_rdy;
   logic [15:0]              beats_out;

   word_packer #(.WORD_W(WORD_W), .LANES(LANES), .CNT_W(16)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .in_enq_ena  (in_enq_ena),
      .in_enq_v    (in_enq_v),
      .in_enq_last (in_enq_last),
      .in_enq_rdy  (in_enq_rdy),
      .out_enq_ena (out_enq_ena),
      .out_enq_v   (out_enq_v),
      .out_enq_rdy (out_enq_rdy),
      .beats_out   (beats_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WORD_W-1:0] m_pend[$];
   bit                m_hv;
   beat_t             m_hold;
   logic [15:0]       m_beats;
   bit                m_live;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: drive, compare against model at negedge, advance model, return just after posedge.
   task automatic cycle(input logic ena, input logic [WORD_W-1:0] w, input logic last,
                        input logic ordy, input logic rst_n);
      bit    exp_rdy, ox, ix;
      beat_t b;
      in_enq_ena  = ena;
      in_enq_v    = w;
      in_enq_last = last;
      out_enq_rdy = ordy;
      nRST        = rst_n;
      @(negedge CLK);
      exp_rdy = !m_hv || ordy;
      if (m_live) begin
         check("in_enq_rdy",  {127'd0, in_enq_rdy},  {127'd0, exp_rdy});
         check("out_enq_ena", {127'd0, out_enq_ena}, {127'd0, m_hv});
         check("out_enq_v",   out_enq_v,             m_hold);
         check("beats_out",   {112'd0, beats_out},   {112'd0, m_beats});
      end
      if (!rst_n) begin
         m_pend.delete();
         m_hv    = 0;
         m_hold  = '0;
         m_beats = '0;
         m_live  = 1;
      end else begin
         ox = m_hv && ordy;
         ix = ena && exp_rdy;
         if (ox) begin
            m_hv    = 0;
            m_beats = m_beats + 16'd1;
         end
         if (ix) begin
            m_pend.push_back(w);
            if (last || m_pend.size() == LANES) begin
               b = '0;
               foreach (m_pend[i]) b[i] = m_pend[i];
               m_hold = b;
               m_hv   = 1;
               m_pend.delete();
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   logic [15:0] b0;

   initial begin
      m_live = 0;
      m_hv = 0; m_hold = '0; m_beats = '0;
      in_enq_ena = 0; in_enq_v = '0; in_enq_last = 0; out_enq_rdy = 0; nRST = 0;

      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);
      check("rst_ena",  {127'd0, out_enq_ena}, 128'd0);
      check("rst_v",    out_enq_v,             128'd0);
      check("rst_beat", {112'd0, beats_out},   128'd0);
      check("rst_rdy",  {127'd0, in_enq_rdy},  128'd1);

      // Full beat
      cycle(1, 32'h11111111, 0, 1, 1);
      cycle(1, 32'h22222222, 0, 1, 1);
      cycle(1, 32'h33333333, 0, 1, 1);
      cycle(1, 32'h44444444, 0, 1, 1);
      check("full_ena", {127'd0, out_enq_ena}, 128'd1);
      check("full_v", out_enq_v, 128'h44444444_33333333_22222222_11111111);
      cycle(0, '0, 0, 1, 1);
      check("full_cnt", {112'd0, beats_out}, 128'd1);

      // Early flush, then a full beat must carry no residue
      cycle(1, 32'hAAAA0001, 0, 1, 1);
      cycle(1, 32'hAAAA0002, 1, 1, 1);
      check("flush_v", out_enq_v, 128'h00000000_00000000_AAAA0002_AAAA0001);
      cycle(1, 32'h5, 0, 1, 1);
      cycle(1, 32'h6, 0, 1, 1);
      cycle(1, 32'h7, 0, 1, 1);
      cycle(1, 32'h8, 0, 1, 1);
      check("nores_v", out_enq_v, 128'h00000008_00000007_00000006_00000005);
      cycle(1, 32'h9, 1, 1, 1);
      check("single_v", out_enq_v, 128'h00000000_00000000_00000000_00000009);
      cycle(0, '0, 0, 1, 1);

      // Downstream stall
      cycle(1, 32'hC1, 0, 0, 1);
      cycle(1, 32'hC2, 0, 0, 1);
      cycle(1, 32'hC3, 0, 0, 1);
      cycle(1, 32'hC4, 0, 0, 1);
      b0 = m_beats;
      for (int i = 0; i < 10; i++) cycle(1, $urandom, $urandom_range(0, 1), 0, 1);
      check("stall_rdy", {127'd0, in_enq_rdy}, 128'd0);
      check("stall_v", out_enq_v, 128'h000000C4_000000C3_000000C2_000000C1);
      check("stall_cnt", {112'd0, beats_out}, {112'd0, b0});
      cycle(0, '0, 0, 1, 1);
      check("unstall_cnt", {112'd0, beats_out}, {112'd0, b0 + 16'd1});
      check("unstall_rdy", {127'd0, in_enq_rdy}, 128'd1);
      check("unstall_ena", {127'd0, out_enq_ena}, 128'd0);

      // Streaming: 40 words back-to-back
      b0 = m_beats;
      for (int i = 0; i < 40; i++) cycle(1, 32'h1000 + i, 0, 1, 1);
      cycle(0, '0, 0, 1, 1);
      check("stream_cnt", {112'd0, beats_out}, {112'd0, b0 + 16'd10});

      // Reset mid-beat discards partial words
      cycle(1, 32'hDEAD0001, 0, 1, 1);
      cycle(1, 32'hDEAD0002, 0, 1, 1);
      cycle(0, '0, 0, 1, 0);
      for (int i = 1; i <= 4; i++) cycle(1, i, 0, 1, 1);
      check("rst_mid_v", out_enq_v, 128'h00000004_00000003_00000002_00000001);
      cycle(0, '0, 0, 1, 1);
      check("rst_mid_cnt", {112'd0, beats_out}, 128'd1);

      // Beat counter wrap
      cycle(0, '0, 0, 1, 0);
      for (int i = 0; i < 65535; i++) cycle(1, i, 1, 1, 1);
      cycle(0, '0, 0, 1, 1);
      check("pre_wrap", {112'd0, beats_out}, 128'hFFFF);
      cycle(1, 32'h77, 1, 1, 1);
      cycle(0, '0, 0, 1, 1);
      check("wrap", {112'd0, beats_out}, 128'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) < 7, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Width-up converter that sits directly upstream of the 128-bit single-entry FIFO stage.
- Accepts 32-bit words over an enq/RDY handshake and packs four consecutive words into one 128-bit beat.
- Presents each beat on an enq-style output to the downstream FIFO's enq method.
- Supports early flush of a partial beat (zero-padded) via a last flag, and counts emitted beats.

Parameters:
- WORD_W, 32: input word width.
- LANES, 4: words per output beat; output width is WORD_W*LANES = 128. Must be a power of two, at least 2.
- CNT_W, 16: width of the emitted-beat counter.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, synchronous, active-low.
- in_enq_ena  input  1  upstream word valid; a transfer occurs when in_enq_ena & in_enq_rdy.
- in_enq_v  input  WORD_W  input word.
- in_enq_last  input  1  word closes the current beat even if fewer than LANES words are collected.
- in_enq_rdy  output  1  packer can accept a word this cycle.
- out_enq_ena  output  1  beat valid toward downstream enq.
- out_enq_v  output  WORD_W*LANES  packed beat; lane 0 is bits [WORD_W-1:0].
- out_enq_rdy  input  1  downstream enq ready; a transfer occurs when out_enq_ena & out_enq_rdy.
- beats_out  output  CNT_W  number of beats transferred downstream, wrapping.

Behaviour:
- State:
  - lane counter cnt: 0..LANES-1.
  - accumulator lanes acc[0..LANES-2].
  - holding register hold_v.
  - flag hold_valid.
  - counter beats.
- Reset (nRST=0 at a CLK edge):
  - cnt=0, acc=0, hold_v=0, hold_valid=0, beats=0.
  - Outputs after reset: out_enq_ena=0, out_enq_v=0, beats_out=0, in_enq_rdy=1.
  - Reset mid-beat discards any partially collected words and any undelivered held beat.
- out_enq_ena = hold_valid; out_enq_v = hold_v; beats_out = beats.
- in_enq_rdy = !hold_valid | out_enq_rdy. This is combinational from out_enq_rdy and is intended.
- Input transfer, when cnt < LANES-1 and last=0:
  - acc[cnt] <= in_enq_v; cnt <= cnt+1.
- Input transfer, when cnt == LANES-1 or last=1 (beat close):
  - hold_v <= { zeros for lanes above cnt, in_enq_v at lane cnt, acc[cnt-1..0] }.
  - hold_valid <= 1; cnt <= 0; acc cleared to 0.
- Lanes above the closing lane are always zero. No stale accumulator data may appear.
- Output transfer with no simultaneous beat close:
  - hold_valid <= 0; beats <= beats+1, wrapping at 2^CNT_W.
- Simultaneous output transfer and beat close in the same cycle:
  - hold_v is reloaded, hold_valid stays 1, beats increments.
  - Full throughput: one beat per LANES input cycles, and one beat per cycle for last-every-word traffic.
- Downstream stall (hold_valid=1, out_enq_rdy=0):
  - in_enq_rdy=0 and no word is accepted.
  - hold_v and out_enq_v stay stable until transferred.
- Latency: the word that closes a beat is visible on out_enq_v in the cycle after acceptance.
- in_enq_v and in_enq_last are ignored when no transfer occurs.
- in_enq_last with cnt=0 produces a single-word beat: lane 0 = word, others 0.

Decomposition:
- Shared package holds:
  - WORD_W, LANES.
  - a beat typedef: array of LANES words of WORD_W bits.
  - a lane-index typedef of $clog2(LANES) bits.
- No sub-module is required. An optional word_lane_mux sub-module may build the zero-padded beat from acc, cnt and the incoming word.

Test Plan:
- Reset then feed 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_enq_rdy=1 -> one cycle after the 4th word: out_enq_ena=1, out_enq_v=0x44444444_33333333_22222222_11111111. On the next cycle beats_out=1.
- Feed 0xAAAA0001, then 0xAAAA0002 with last=1 -> out_enq_v=0x00000000_00000000_AAAA0002_AAAA0001. A following full beat shows no residue in lanes 2-3.
- Hold out_enq_rdy=0 after one beat is formed -> in_enq_rdy=0; out_enq_v stable for 10 cycles; beats_out unchanged. Raise rdy -> beat transferred, beats_out+1, in_enq_rdy=1.
- Stream 40 words continuously with out_enq_rdy=1 -> 10 beats, in_enq_rdy never drops, beats_out=10, data order preserved.
- Send 2 words, pull nRST low for 1 cycle, then send 4 words 0x1..0x4 -> single beat 0x4_3_2_1. The pre-reset words never appear; beats_out counts from 0.
- Preload beats=0xFFFF via 0xFFFF beats, send one more -> beats_out wraps to 0x0000.
